// File: rtl/thread_ctrl_bank_pkg.sv
// Shared types for the multi-thread control bank: command/response encodings,
// the per-thread state record and a small index-range helper.
package thrd_pkg;

  localparam int MAX_TID_W = 5;
  localparam int MAX_PC_W  = 64;

  localparam logic [MAX_PC_W-1:0] DEF_START_PC = '0;

  typedef enum logic [1:0] {
    CMD_INIT = 2'd0,
    CMD_SLP  = 2'd1,
    CMD_WAKE = 2'd2,
    CMD_KILL = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    RSP_OK            = 2'd0,
    RSP_NOT_VALID     = 2'd1,
    RSP_ALREADY_VALID = 2'd2,
    RSP_NOT_PARENT    = 2'd3
  } rsp_code_e;

  // Fields are sized for the largest supported configuration; instances cast down.
  typedef struct packed {
    logic                 valid;
    logic                 running;
    logic [MAX_TID_W-1:0] parent;
    logic [MAX_PC_W-1:0]  pc;
  } thrd_state_t;

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/thread_ctrl_bank_if.sv
// Command, PC write-back, issue and status signals of the thread control bank.
interface thread_ctrl_bank_if #(
  parameter int NUM_THRD = 8,
  parameter int TID_W    = $clog2(NUM_THRD),
  parameter int PC_W     = 32
);
  logic                cmd_vld;
  logic [1:0]          cmd_op;
  logic [TID_W-1:0]    cmd_obj;
  logic [TID_W-1:0]    cmd_act;
  logic [PC_W-1:0]     cmd_pc;
  logic                rsp_vld;
  logic                rsp_err;
  logic [1:0]          rsp_code;
  logic                pc_wr;
  logic [TID_W-1:0]    pc_wr_thrd;
  logic [PC_W-1:0]     pc_wr_val;
  logic                iss_rdy;
  logic                iss_vld;
  logic [TID_W-1:0]    iss_thrd;
  logic [PC_W-1:0]     iss_pc;
  logic [NUM_THRD-1:0] thrd_valid;
  logic [NUM_THRD-1:0] thrd_running;
  logic                error;

  modport master (
    output cmd_vld, cmd_op, cmd_obj, cmd_act, cmd_pc,
    output pc_wr, pc_wr_thrd, pc_wr_val, iss_rdy,
    input  rsp_vld, rsp_err, rsp_code,
    input  iss_vld, iss_thrd, iss_pc, thrd_valid, thrd_running, error
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_obj, cmd_act, cmd_pc,
    input  pc_wr, pc_wr_thrd, pc_wr_val, iss_rdy,
    output rsp_vld, rsp_err, rsp_code,
    output iss_vld, iss_thrd, iss_pc, thrd_valid, thrd_running, error
  );
endinterface

// File: rtl/thread_ctrl_bank_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    int s;
    logic [IDX_W-1:0] j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    s       = 0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      j = IDX_W'(s);
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/thread_ctrl_bank.sv
// Control/status, PC and round-robin issue selection for NUM_THRD hardware threads.
// Optional: define THRD_KILL_CASCADE_EN so a KILL also removes the victim's direct children.
module thread_ctrl_bank
  import thrd_pkg::*;
#(
  parameter int              NUM_THRD = 8,
  parameter int              TID_W    = $clog2(NUM_THRD),
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] START_PC = PC_W'(DEF_START_PC)
) (
  input logic               clk,
  input logic               rst_n,
  thread_ctrl_bank_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_THRD);
  typedef logic [IDX_W-1:0] idx_t;

  thrd_state_t state_q [NUM_THRD];
  thrd_state_t state_d [NUM_THRD];
  idx_t        ptr_q, ptr_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_err_q, rsp_err_d;
  rsp_code_e   rsp_code_q, rsp_code_d;
  logic        error_q, error_d;

  logic [NUM_THRD-1:0]  valid_vec, run_vec;
  logic                 gnt_vld;
  idx_t                 gnt_idx, sel_idx;
  logic                 obj_ok, act_ok, obj_valid, act_valid, pcw_ok;
  idx_t                 obj_idx, act_idx, pcw_idx;
  logic [MAX_TID_W-1:0] act_ext;
  rsp_code_e            code;

  always_comb begin
    for (int i = 0; i < NUM_THRD; i++) begin
      valid_vec[i] = state_q[i].valid;
      run_vec[i]   = state_q[i].running;
    end
  end

  rr_arbiter #(.N(NUM_THRD), .IDX_W(IDX_W)) u_arb (
    .req     (run_vec),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign sel_idx = gnt_vld ? gnt_idx : '0;

  // Checks run in a fixed priority order; the first failing one names the error.
  always_comb begin
    obj_ok    = idx_in_range(32'(bus.cmd_obj), NUM_THRD);
    act_ok    = idx_in_range(32'(bus.cmd_act), NUM_THRD);
    obj_idx   = obj_ok ? idx_t'(bus.cmd_obj) : '0;
    act_idx   = act_ok ? idx_t'(bus.cmd_act) : '0;
    obj_valid = obj_ok && state_q[obj_idx].valid;
    act_valid = act_ok && state_q[act_idx].valid;
    act_ext   = MAX_TID_W'(bus.cmd_act);
    pcw_ok    = idx_in_range(32'(bus.pc_wr_thrd), NUM_THRD);
    pcw_idx   = pcw_ok ? idx_t'(bus.pc_wr_thrd) : '0;
    code      = RSP_OK;
    if (!obj_ok) begin
      code = RSP_NOT_VALID;
    end else begin
      case (cmd_op_e'(bus.cmd_op))
        CMD_INIT: begin
          if (obj_valid)       code = RSP_ALREADY_VALID;
          else if (!act_valid) code = RSP_NOT_VALID;
        end
        CMD_SLP: begin
          if (!obj_valid)                               code = RSP_NOT_VALID;
          else if (state_q[obj_idx].parent != act_ext) code = RSP_NOT_PARENT;
        end
        CMD_WAKE: begin
          if (!obj_valid) code = RSP_NOT_VALID;
        end
        CMD_KILL: begin
          if (obj_idx == '0)                            code = RSP_NOT_PARENT;
          else if (!obj_valid)                          code = RSP_NOT_VALID;
          else if (state_q[obj_idx].parent != act_ext) code = RSP_NOT_PARENT;
        end
        default: code = RSP_OK;
      endcase
    end
  end

  // PC write-back is applied before the command so an INIT's PC overrides it.
  always_comb begin
    state_d = state_q;
    if (bus.pc_wr && pcw_ok && state_q[pcw_idx].valid) begin
      state_d[pcw_idx].pc = MAX_PC_W'(bus.pc_wr_val);
    end
    if (bus.cmd_vld && code == RSP_OK) begin
      case (cmd_op_e'(bus.cmd_op))
        CMD_INIT: begin
          state_d[obj_idx].valid   = 1'b1;
          state_d[obj_idx].running = 1'b1;
          state_d[obj_idx].parent  = act_ext;
          state_d[obj_idx].pc      = MAX_PC_W'(bus.cmd_pc);
        end
        CMD_SLP:  state_d[obj_idx].running = 1'b0;
        CMD_WAKE: state_d[obj_idx].running = 1'b1;
        CMD_KILL: begin
          state_d[obj_idx].valid   = 1'b0;
          state_d[obj_idx].running = 1'b0;
`ifdef THRD_KILL_CASCADE_EN
          for (int i = 0; i < NUM_THRD; i++) begin
            if (state_q[i].parent == MAX_TID_W'(obj_idx)) begin
              state_d[i].valid   = 1'b0;
              state_d[i].running = 1'b0;
            end
          end
`endif
        end
        default: ;
      endcase
    end

    ptr_d = ptr_q;
    if (gnt_vld && bus.iss_rdy) begin
      ptr_d = (gnt_idx == idx_t'(NUM_THRD - 1)) ? '0 : gnt_idx + 1'b1;
    end

    rsp_vld_d  = bus.cmd_vld;
    rsp_err_d  = bus.cmd_vld && (code != RSP_OK);
    rsp_code_d = bus.cmd_vld ? code : RSP_OK;
    error_d    = error_q | (|(run_vec & ~valid_vec));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_THRD; i++) begin
        state_q[i].valid   <= (i == 0);
        state_q[i].running <= (i == 0);
        state_q[i].parent  <= '0;
        state_q[i].pc      <= MAX_PC_W'(START_PC);
      end
      ptr_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_code_q <= RSP_OK;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_code_q <= rsp_code_d;
      error_q    <= error_d;
    end
  end

  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_code     = rsp_code_q;
  assign bus.iss_vld      = gnt_vld;
  assign bus.iss_thrd     = TID_W'(sel_idx);
  assign bus.iss_pc       = PC_W'(state_q[sel_idx].pc);
  assign bus.thrd_valid   = valid_vec;
  assign bus.thrd_running = run_vec;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_thread_ctrl_bank.sv
// Self-checking bench for thread_ctrl_bank: directed scenarios plus randomized
// traffic compared against an array-based model of the thread rules.
module tb_thread_ctrl_bank;
  import thrd_pkg::*;

  localparam int N  = 8;
  localparam int TW = 4;
  localparam int PW = 32;

  logic clk;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  bit              mval [N];
  bit              mrun [N];
  int              mpar [N];
  logic [PW-1:0]   mpc  [N];
  int              mptr;
  bit              m_rsp_vld;
  int              m_rsp_code;

  thread_ctrl_bank_if #(.NUM_THRD(N), .TID_W(TW), .PC_W(PW)) bus ();

  thread_ctrl_bank #(.NUM_THRD(N), .TID_W(TW), .PC_W(PW), .START_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mval[i] = (i == 0); mrun[i] = (i == 0); mpar[i] = 0; mpc[i] = 32'h0;
    end
    mptr = 0; m_rsp_vld = 0; m_rsp_code = 0;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++) if (mrun[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  function automatic int model_code(int op, int obj, int act);
    if (obj >= N) return 1;
    case (op)
      0: begin if (mval[obj]) return 2; if (act >= N || !mval[act]) return 1; return 0; end
      1: begin if (!mval[obj]) return 1; if (mpar[obj] != act) return 3; return 0; end
      2: begin if (!mval[obj]) return 1; return 0; end
      default: begin
        if (obj == 0) return 3; if (!mval[obj]) return 1; if (mpar[obj] != act) return 3; return 0;
      end
    endcase
  endfunction

  function automatic logic [N-1:0] model_vvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mval[i];
    return v;
  endfunction

  function automatic logic [N-1:0] model_rvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mrun[i];
    return v;
  endfunction

  function automatic int model_iss();
    int g;
    g = model_pick();
    return (g < 0) ? 0 : g;
  endfunction

  // Advances the model by one clock edge using the inputs currently on the bus.
  task automatic model_edge();
    bit nv [N]; bit nr [N]; int np [N]; logic [PW-1:0] npc [N];
    int g, code, obj, act, op, wt;
    nv = mval; nr = mrun; np = mpar; npc = mpc;
    g = model_pick();
    op = int'(bus.cmd_op); obj = int'(bus.cmd_obj); act = int'(bus.cmd_act);
    code = model_code(op, obj, act);
    wt = int'(bus.pc_wr_thrd);
    if (bus.pc_wr && wt < N && mval[wt]) npc[wt] = bus.pc_wr_val;
    if (bus.cmd_vld && code == 0) begin
      case (op)
        0: begin nv[obj] = 1; nr[obj] = 1; np[obj] = act; npc[obj] = bus.cmd_pc; end
        1: nr[obj] = 0;
        2: nr[obj] = 1;
        default: begin
          nv[obj] = 0; nr[obj] = 0;
`ifdef THRD_KILL_CASCADE_EN
          for (int i = 0; i < N; i++) if (mpar[i] == obj) begin nv[i] = 0; nr[i] = 0; end
`endif
        end
      endcase
    end
    if (g >= 0 && bus.iss_rdy) mptr = (g + 1) % N;
    m_rsp_vld = bus.cmd_vld; m_rsp_code = bus.cmd_vld ? code : 0;
    mval = nv; mrun = nr; mpar = np; mpc = npc;
  endtask

  task automatic applyStimulus(input bit cv, input int op, input int obj, input int act,
                               input logic [PW-1:0] pc, input bit pw, input int pwt,
                               input logic [PW-1:0] pwv, input bit rdy);
    bus.cmd_vld = cv; bus.cmd_op = 2'(op); bus.cmd_obj = TW'(obj); bus.cmd_act = TW'(act);
    bus.cmd_pc = pc; bus.pc_wr = pw; bus.pc_wr_thrd = TW'(pwt); bus.pc_wr_val = pwv;
    bus.iss_rdy = rdy;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_vld = 1'b1; bus.cmd_op = 2'd0; bus.cmd_obj = 4'd3; bus.cmd_act = 4'd0;
    bus.cmd_pc = 32'h100; bus.pc_wr = 1'b0; bus.pc_wr_thrd = '0; bus.pc_wr_val = '0;
    bus.iss_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (bus.thrd_valid !== 8'h01) begin nerr++; $display("[TB] FAIL in_reset_valid got %h want 01", bus.thrd_valid); end
    nvec++; if (bus.rsp_vld !== 1'b0) begin nerr++; $display("[TB] FAIL in_reset_rsp_vld got %b want 0", bus.rsp_vld); end
    bus.cmd_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    nvec++; if (bus.thrd_valid !== 8'h01) begin nerr++; $display("[TB] FAIL reset_valid got %h want 01", bus.thrd_valid); end
    nvec++; if (bus.thrd_running !== 8'h01) begin nerr++; $display("[TB] FAIL reset_running got %h want 01", bus.thrd_running); end
    nvec++; if (bus.iss_vld !== 1'b1) begin nerr++; $display("[TB] FAIL reset_iss_vld got %b want 1", bus.iss_vld); end
    nvec++; if (bus.iss_thrd !== 4'd0) begin nerr++; $display("[TB] FAIL reset_iss_thrd got %0d want 0", bus.iss_thrd); end
    nvec++; if (bus.iss_pc !== 32'h0) begin nerr++; $display("[TB] FAIL reset_iss_pc got %h want 0", bus.iss_pc); end
    nvec++; if (bus.rsp_vld !== 1'b0) begin nerr++; $display("[TB] FAIL reset_rsp_vld got %b want 0", bus.rsp_vld); end
    nvec++; if (bus.error !== 1'b0) begin nerr++; $display("[TB] FAIL reset_error got %b want 0", bus.error); end
  endtask

  task automatic test_init();
    applyStimulus(1, 0, 3, 0, 32'h100, 0, 0, 0, 0);
    nvec++; if (bus.rsp_vld !== 1'b1) begin nerr++; $display("[TB] FAIL init_rsp_vld got %b want 1", bus.rsp_vld); end
    nvec++; if (bus.rsp_code !== 2'd0) begin nerr++; $display("[TB] FAIL init_code got %0d want 0", bus.rsp_code); end
    nvec++; if (bus.rsp_err !== 1'b0) begin nerr++; $display("[TB] FAIL init_err got %b want 0", bus.rsp_err); end
    nvec++; if (bus.thrd_valid !== 8'h09) begin nerr++; $display("[TB] FAIL init_valid got %h want 09", bus.thrd_valid); end
    applyStimulus(1, 0, 3, 0, 32'h200, 0, 0, 0, 0);
    nvec++; if (bus.rsp_code !== 2'd2) begin nerr++; $display("[TB] FAIL reinit_code got %0d want 2", bus.rsp_code); end
    nvec++; if (bus.rsp_err !== 1'b1) begin nerr++; $display("[TB] FAIL reinit_err got %b want 1", bus.rsp_err); end
    nvec++; if (bus.thrd_valid !== 8'h09) begin nerr++; $display("[TB] FAIL reinit_valid got %h want 09", bus.thrd_valid); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nvec++; if (bus.rsp_vld !== 1'b0) begin nerr++; $display("[TB] FAIL idle_rsp_vld got %b want 0", bus.rsp_vld); end
  endtask

  task automatic test_issue_rotation();
    int exp_seq [4] = '{3, 0, 3, 0};
    nvec++; if (bus.iss_thrd !== 4'd0) begin nerr++; $display("[TB] FAIL rot_start got %0d want 0", bus.iss_thrd); end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      nvec++; if (bus.iss_thrd !== TW'(exp_seq[c])) begin nerr++; $display("[TB] FAIL rot_thrd[%0d] got %0d want %0d", c, bus.iss_thrd, exp_seq[c]); end
      if (exp_seq[c] == 3) begin
        nvec++; if (bus.iss_pc !== 32'h100) begin nerr++; $display("[TB] FAIL rot_pc[%0d] got %h want 100", c, bus.iss_pc); end
      end
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      nvec++; if (bus.iss_thrd !== 4'd0) begin nerr++; $display("[TB] FAIL hold_thrd[%0d] got %0d want 0", c, bus.iss_thrd); end
    end
  endtask

  task automatic test_sleep_wake();
    applyStimulus(1, 1, 3, 5, 0, 0, 0, 0, 0);
    nvec++; if (bus.rsp_code !== 2'd3) begin nerr++; $display("[TB] FAIL slp_np_code got %0d want 3", bus.rsp_code); end
    nvec++; if (bus.thrd_running !== 8'h09) begin nerr++; $display("[TB] FAIL slp_np_run got %h want 09", bus.thrd_running); end
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0);
    nvec++; if (bus.rsp_code !== 2'd0) begin nerr++; $display("[TB] FAIL slp_ok_code got %0d want 0", bus.rsp_code); end
    nvec++; if (bus.thrd_running !== 8'h01) begin nerr++; $display("[TB] FAIL slp_ok_run got %h want 01", bus.thrd_running); end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      nvec++; if (bus.iss_thrd !== 4'd0) begin nerr++; $display("[TB] FAIL slp_iss[%0d] got %0d want 0", c, bus.iss_thrd); end
    end
    applyStimulus(1, 2, 3, 7, 0, 0, 0, 0, 0);
    nvec++; if (bus.rsp_code !== 2'd0) begin nerr++; $display("[TB] FAIL wake_code got %0d want 0", bus.rsp_code); end
    nvec++; if (bus.thrd_running !== 8'h09) begin nerr++; $display("[TB] FAIL wake_run got %h want 09", bus.thrd_running); end
    nvec++; if (bus.iss_thrd !== 4'd3) begin nerr++; $display("[TB] FAIL wake_iss got %0d want 3", bus.iss_thrd); end
  endtask

  task automatic test_errors();
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h3c, 0);
    nvec++; if (bus.iss_pc !== 32'h3c) begin nerr++; $display("[TB] FAIL pcwr_pc got %h want 3c", bus.iss_pc); end
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0);
    nvec++; if (bus.rsp_code !== 2'd3) begin nerr++; $display("[TB] FAIL kill_root_code got %0d want 3", bus.rsp_code); end
    nvec++; if (bus.thrd_valid !== 8'h09) begin nerr++; $display("[TB] FAIL kill_root_valid got %h want 09", bus.thrd_valid); end
    applyStimulus(1, 2, 9, 0, 0, 0, 0, 0, 0);
    nvec++; if (bus.rsp_code !== 2'd1) begin nerr++; $display("[TB] FAIL obj_range_code got %0d want 1", bus.rsp_code); end
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 32'h44, 0);
    nvec++; if (bus.thrd_valid !== 8'h09) begin nerr++; $display("[TB] FAIL pcwr_inv_valid got %h want 09", bus.thrd_valid); end
    nvec++; if (bus.iss_pc !== 32'h3c) begin nerr++; $display("[TB] FAIL pcwr_inv_pc got %h want 3c", bus.iss_pc); end
  endtask

  task automatic test_kill_cascade();
    logic [7:0] exp_v;
`ifdef THRD_KILL_CASCADE_EN
    exp_v = 8'h01;
`else
    exp_v = 8'h11;
`endif
    applyStimulus(1, 0, 4, 3, 32'h400, 0, 0, 0, 0);
    nvec++; if (bus.thrd_valid !== 8'h19) begin nerr++; $display("[TB] FAIL init_child_valid got %h want 19", bus.thrd_valid); end
    applyStimulus(1, 3, 3, 0, 0, 0, 0, 0, 0);
    nvec++; if (bus.rsp_code !== 2'd0) begin nerr++; $display("[TB] FAIL kill_code got %0d want 0", bus.rsp_code); end
    nvec++; if (bus.thrd_valid !== exp_v) begin nerr++; $display("[TB] FAIL kill_valid got %h want %h", bus.thrd_valid, exp_v); end
    nvec++; if (bus.thrd_running !== exp_v) begin nerr++; $display("[TB] FAIL kill_run got %h want %h", bus.thrd_running, exp_v); end
    nvec++; if (bus.error !== 1'b0) begin nerr++; $display("[TB] FAIL kill_error got %b want 0", bus.error); end
  endtask

  task automatic test_random();
    int obj, act;
    for (int c = 0; c < 600; c++) begin
      obj = $urandom_range(0, 9);
      act = $urandom_range(0, 8);
      if (obj < N && $urandom_range(0, 1) == 1) act = mpar[obj];
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 3), obj, act, $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 9), $urandom, $urandom_range(0, 1));
      nvec++; if (bus.rsp_vld !== m_rsp_vld) begin nerr++; $display("[TB] FAIL rnd_rsp_vld c%0d got %b want %b", c, bus.rsp_vld, m_rsp_vld); end
      if (m_rsp_vld) begin
        nvec++; if (bus.rsp_code !== 2'(m_rsp_code)) begin nerr++; $display("[TB] FAIL rnd_code c%0d got %0d want %0d", c, bus.rsp_code, m_rsp_code); end
        nvec++; if (bus.rsp_err !== (m_rsp_code != 0)) begin nerr++; $display("[TB] FAIL rnd_err c%0d got %b want %b", c, bus.rsp_err, m_rsp_code != 0); end
      end
      nvec++; if (bus.thrd_valid !== model_vvec()) begin nerr++; $display("[TB] FAIL rnd_valid c%0d got %h want %h", c, bus.thrd_valid, model_vvec()); end
      nvec++; if (bus.thrd_running !== model_rvec()) begin nerr++; $display("[TB] FAIL rnd_run c%0d got %h want %h", c, bus.thrd_running, model_rvec()); end
      nvec++; if (bus.iss_vld !== (|model_rvec())) begin nerr++; $display("[TB] FAIL rnd_iss_vld c%0d got %b want %b", c, bus.iss_vld, |model_rvec()); end
      nvec++; if (bus.iss_thrd !== TW'(model_iss())) begin nerr++; $display("[TB] FAIL rnd_iss_thrd c%0d got %0d want %0d", c, bus.iss_thrd, model_iss()); end
      nvec++; if (bus.iss_pc !== mpc[model_iss()]) begin nerr++; $display("[TB] FAIL rnd_iss_pc c%0d got %h want %h", c, bus.iss_pc, mpc[model_iss()]); end
      nvec++; if (bus.error !== 1'b0) begin nerr++; $display("[TB] FAIL rnd_error c%0d got %b want 0", c, bus.error); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_issue_rotation();
    test_sleep_wake();
    test_errors();
    test_kill_cascade();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/thread_ctrl_bank.md
Name: thread_ctrl_bank

Overview:
- Parametrised successor to the single-thread CSR: one block holds control/status and PC for all NUM_THRD hardware threads.
- Takes one thread-management command per cycle (init/sleep/wake/kill) and returns a registered response with an error code.
- Accepts PC write-back from the pipeline.
- Round-robin selects the next running thread for the fetch stage.

Parameters:
NUM_THRD, 8, number of hardware threads (2..32)
TID_W, $clog2(NUM_THRD), thread-ID width
PC_W, 32, PC width
START_PC, 32'h0000_0000 (PC_W bits), reset PC of root thread 0

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cmd_vld  in  1  command strobe
cmd_op  in  2  command: 0 INIT, 1 SLP, 2 WAKE, 3 KILL
cmd_obj  in  TID_W  objective (target) thread
cmd_act  in  TID_W  acting (issuing) thread
cmd_pc  in  PC_W  start PC, INIT only
rsp_vld  out  1  response strobe, one cycle after cmd_vld
rsp_err  out  1  command rejected
rsp_code  out  2  0 OK, 1 NOT_VALID, 2 ALREADY_VALID, 3 NOT_PARENT
pc_wr  in  1  PC write-back strobe
pc_wr_thrd  in  TID_W  thread being written
pc_wr_val  in  PC_W  next PC
iss_rdy  in  1  fetch accepts selection
iss_vld  out  1  at least one thread running
iss_thrd  out  TID_W  selected thread
iss_pc  out  PC_W  PC of selected thread
thrd_valid  out  NUM_THRD  per-thread valid
thrd_running  out  NUM_THRD  per-thread running
error  out  1  sticky internal-consistency error

Behaviour:
- Reset (async, rst_n low):
  - thread 0: valid=1, running=1, parent=0, pc=START_PC.
  - threads 1..N-1: valid=0, running=0, parent=0, pc=START_PC.
  - rr pointer=0; rsp_vld=0, rsp_err=0, rsp_code=0; error=0.
  - Reset mid-command discards the command; no response is produced.
- Command checks, evaluated in this order (first failing check sets the code):
  - cmd_obj >= NUM_THRD -> NOT_VALID.
  - INIT: obj valid -> ALREADY_VALID; act not valid -> NOT_VALID. Else valid=1, running=1, parent=act, pc=cmd_pc.
  - SLP: obj not valid -> NOT_VALID; act != parent(obj) -> NOT_PARENT. Else running=0. Sleeping an already-sleeping thread returns OK.
  - WAKE: obj not valid -> NOT_VALID. Else running=1; any actor may wake.
  - KILL: obj==0 -> NOT_PARENT (root is unkillable); obj not valid -> NOT_VALID; act != parent -> NOT_PARENT. Else valid=0, running=0.
- Response timing: state update and response register on the same edge. rsp_vld/rsp_err/rsp_code are valid for exactly one cycle after cmd_vld. A rejected command changes no state.
- PC write: if pc_wr and thread pc_wr_thrd is valid, pc <= pc_wr_val next cycle. Writes to invalid or out-of-range threads are ignored silently. Same cycle and same thread as an accepted INIT: the INIT PC wins.
- Issue:
  - iss_vld = |thrd_running.
  - iss_thrd = first running thread at or after the rr pointer, wrapping at NUM_THRD-1 -> 0.
  - iss_pc = pc[iss_thrd]; iss outputs are combinational from registered state.
  - On iss_vld & iss_rdy, pointer <= iss_thrd+1, wrapping to 0 after NUM_THRD-1. Otherwise the pointer holds.
  - When iss_vld=0, iss_thrd=0 and iss_pc=pc[0].
- Simultaneous events: a grant and a SLP/KILL of the same thread in one cycle both complete; the thread is excluded from the next cycle onward. pc_wr on a just-killed thread in the same cycle still writes; the value is harmless.
- error: set and held until reset if any thread has running & !valid. It must never assert in a legal design.

Optional Feature:
- THRD_KILL_CASCADE_EN defined: an accepted KILL of thread X also clears valid/running of every thread whose parent==X in the same edge. This is one level only; grandchildren become orphans but remain valid.
- Not defined: only X is killed and its children keep running.

Decomposition:
- Package thrd_pkg holds:
  - cmd_op_e enum: INIT, SLP, WAKE, KILL.
  - rsp_code_e enum: OK, NOT_VALID, ALREADY_VALID, NOT_PARENT.
  - START_PC default.
  - A per-thread struct {valid, running, parent, pc}.
- One sub-module: rr_arbiter (parameter N; inputs req[N], ptr; outputs gnt_vld, gnt_idx). It is reusable by later schedulers.

Test Plan:
- Reset release -> thrd_valid=8'h01, thrd_running=8'h01, iss_vld=1, iss_thrd=0, iss_pc=START_PC; rsp_vld=0.
- INIT obj=3 act=0 pc=0x100 -> next cycle rsp OK, thrd_valid=8'h09, parent[3]=0. Repeat the same INIT -> ALREADY_VALID, no state change.
- With threads 0 and 3 running and iss_rdy=1 held -> iss_thrd alternates 0,3,0,3; with iss_rdy=0 -> iss_thrd stays constant.
- SLP obj=3 act=5 -> NOT_PARENT, thread 3 still running. SLP obj=3 act=0 -> OK, thread 3 drops from the issue rotation. WAKE obj=3 act=7 -> OK, thread 3 rejoins.
- KILL obj=0 act=0 -> NOT_PARENT. cmd_obj=9 with NUM_THRD=8 -> NOT_VALID. pc_wr thrd=5 (invalid) val=0x44 -> pc[5] unchanged.
- INIT 3 (parent 0), then INIT 4 with act=3, then KILL 3 act=0:
  - With THRD_KILL_CASCADE_EN: thrd_valid=8'h01.
  - Without it: thrd_valid=8'h11.
  - error stays 0 throughout.
